pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter DWIDTH, default 32, address/PC width.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, first fetch address after reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0100, redirect address on any trap.
REQ-004 Clk  input  1  clock; all state updates on rising edge.
REQ-005 N_Rst  input  1  asynchronous, active-low reset.
REQ-006 Stall  input  1  hold current PC; no advance, no branch/jump.
REQ-007 Fetch_Ack  input  1  instruction memory accepted the current fetch.
REQ-008 Branch_Taken  input  1  conditional branch resolved taken.
REQ-009 Branch_Target  input  DWIDTH  branch destination.
REQ-010 Jump  input  1  JAL/JALR.
REQ-011 Jump_Target  input  DWIDTH  jump destination; bit 0 cleared internally.
REQ-012 Trap_Req  input  1  synchronous exception request (ECALL, illegal opcode).
REQ-013 PC  output  DWIDTH  registered current fetch address.
REQ-014 PC_Plus4  output  DWIDTH  combinational PC+4, modulo 2^DWIDTH.
REQ-015 Fetch_Req  output  1  fetch valid this cycle.
REQ-016 Trap_Flag  output  1  one-cycle pulse when a trap redirect is taken.
REQ-017 Epc  output  DWIDTH  PC of the trapping instruction.
REQ-018 Seq_State  output  2  current FSM state encoding.

Function
REQ-019 The FSM SHALL have states BOOT=0, RUN=1, HOLD=2, TRAP=3.
REQ-020 BOOT: Fetch_Req=0; the next state SHALL be RUN unconditionally after one cycle.
REQ-021 RUN: Fetch_Req=1; PC SHALL advance only on a cycle with Fetch_Ack=1 and Stall=0.
REQ-022 Next-PC priority: Trap_Req > misaligned target > Jump > Branch_Taken > PC_Plus4.
REQ-023 RUN with Stall=1: PC SHALL hold and the state SHALL move to HOLD; Fetch_Ack, Jump and Branch_Taken ignored.
REQ-024 RUN with Fetch_Ack=0 and Stall=0: PC SHALL hold and the state SHALL remain RUN.
REQ-025 HOLD: Fetch_Req=0 and PC held; the state SHALL return to RUN on the first cycle Stall=0.
REQ-026 Trap_Req=1 in RUN or HOLD SHALL, regardless of Stall/Fetch_Ack, set Epc<=PC, PC<=TRAP_VEC, pulse Trap_Flag and enter TRAP.
REQ-027 TRAP: Fetch_Req=0 for one cycle; Trap_Req ignored; the next state SHALL be RUN.
REQ-028 Trap_Req in BOOT SHALL be ignored.
REQ-029 PC+4 wraps: PC=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-030 Jump and Branch_Taken asserted together: Jump_Target SHALL win.

Reset
REQ-031 With N_Rst=0: PC=RESET_VEC, Epc=0, Trap_Flag=0, Fetch_Req=0, state BOOT, asynchronously.
REQ-032 Reset asserted mid-HOLD or mid-TRAP SHALL discard the pending redirect; the sequence restarts at BOOT.

Configuration
REQ-033 Macro PC_SEQ_MISALIGN_TRAP_EN defined: a selected Jump/Branch target with bits[1:0]!=0 (after Jump bit-0 clear) SHALL be handled as Trap_Req (Epc<=PC, PC<=TRAP_VEC).
REQ-034 Macro undefined: no misalignment check; target bits[1:0] SHALL be forced to 0 and loaded.

Structure
REQ-035 Package pc_seq_pkg SHALL hold the state enum (seq_state_t), the next-PC select enum (BOOT/SEQ/BR/JMP/TRAP) and the default RESET_VEC/TRAP_VEC constants.
REQ-036 Sub-module pc_next_mux SHALL implement the combinational priority selection and misalignment detection; the FSM and registers stay in pc_sequencer.

Verification
REQ-037 Reset release, Fetch_Ack=1 -> cycle 1 BOOT Fetch_Req=0 PC=0; then PC=0,4,8,12 each cycle.
REQ-038 PC=0x10, Branch_Taken=1 Target=0x40, Fetch_Ack=1 -> PC=0x40 next cycle; same with Stall=1 -> PC stays 0x10, state HOLD.
REQ-039 PC=0x20, Jump=1 Target=0x81, Branch_Taken=1 Target=0x40 -> PC=0x80, no trap.
REQ-040 PC=0x30, Branch_Taken=1 Target=0x42, macro defined -> PC=0x100, Epc=0x30, Trap_Flag one cycle; undefined -> PC=0x40.
REQ-041 PC=0x50, Stall=1, Trap_Req=1 -> PC=0x100, Epc=0x50, TRAP one cycle then RUN.
REQ-042 PC=32'hFFFF_FFFC, Fetch_Ack=1 -> PC=0; N_Rst pulsed low in HOLD -> PC=RESET_VEC immediately, state BOOT.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and default vectors for the PC sequencer
// Contents:
//   seq_state_t   : sequencer FSM state (BOOT=0, RUN=1, HOLD=2, TRAP=3)
//   pc_sel_t      : next-PC source chosen by pc_next_mux
//   DEF_RESET_VEC : default first fetch address after reset
//   DEF_TRAP_VEC  : default trap redirect address
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_TRAP = 2'd3
  } seq_state_t;

  typedef enum logic [2:0] {
    SEL_BOOT,
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_TRAP
  } pc_sel_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational next-PC priority select and misalignment check
// Macro: PC_SEQ_MISALIGN_TRAP_EN (defined: misaligned jump/branch target selects the trap vector)
// Ports:
//   pc            in  current PC
//   trap_req      in  synchronous exception request
//   jump          in  jump request; jump_target bit 0 is cleared here
//   jump_target   in  jump destination
//   branch_taken  in  conditional branch resolved taken
//   branch_target in  branch destination
//   pc_plus4      out pc + 4, wrapping
//   next_pc       out selected next PC
//   sel           out which source was selected
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int unsigned       DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] TRAP_VEC = DWIDTH'(DEF_TRAP_VEC)
) (
  input  logic [DWIDTH-1:0] pc,
  input  logic              trap_req,
  input  logic              jump,
  input  logic [DWIDTH-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [DWIDTH-1:0] branch_target,
  output logic [DWIDTH-1:0] pc_plus4,
  output logic [DWIDTH-1:0] next_pc,
  output pc_sel_t           sel
);

  localparam logic [DWIDTH-1:0] ALIGN_MASK = ~DWIDTH'(3);
  localparam logic [DWIDTH-1:0] JALR_MASK  = ~DWIDTH'(1);

  logic [DWIDTH-1:0] tgt;
  logic              misaligned;

  assign pc_plus4 = pc + DWIDTH'(4);

  // Jump beats branch, so the jump target is the one checked and loaded.
  assign tgt = jump ? (jump_target & JALR_MASK) : branch_target;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  assign misaligned = (jump || branch_taken) && (tgt[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc_plus4;
    if (trap_req || misaligned) begin
      sel     = SEL_TRAP;
      next_pc = TRAP_VEC;
    end else if (jump) begin
      sel     = SEL_JMP;
      next_pc = tgt & ALIGN_MASK;
    end else if (branch_taken) begin
      sel     = SEL_BR;
      next_pc = tgt & ALIGN_MASK;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction fetch PC sequencer with stall, branch/jump and trap redirect
// Macro: PC_SEQ_MISALIGN_TRAP_EN (defined: misaligned jump/branch target traps; otherwise low bits forced to 0)
// Ports:
//   Clk, N_Rst                  clock, asynchronous active-low reset
//   Stall                       hold PC, move RUN to HOLD
//   Fetch_Ack                   fetch accepted; PC advances in RUN
//   Branch_Taken/Branch_Target  conditional branch redirect
//   Jump/Jump_Target            JAL/JALR redirect
//   Trap_Req                    exception request
//   PC, PC_Plus4                current fetch address and its successor
//   Fetch_Req                   fetch valid (RUN only)
//   Trap_Flag                   one-cycle pulse after a trap redirect
//   Epc                         PC of the trapping instruction
//   Seq_State                   current FSM state
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       DWIDTH    = 32,
  parameter logic [DWIDTH-1:0] RESET_VEC = DWIDTH'(DEF_RESET_VEC),
  parameter logic [DWIDTH-1:0] TRAP_VEC  = DWIDTH'(DEF_TRAP_VEC)
) (
  input  logic              Clk,
  input  logic              N_Rst,
  input  logic              Stall,
  input  logic              Fetch_Ack,
  input  logic              Branch_Taken,
  input  logic [DWIDTH-1:0] Branch_Target,
  input  logic              Jump,
  input  logic [DWIDTH-1:0] Jump_Target,
  input  logic              Trap_Req,
  output logic [DWIDTH-1:0] PC,
  output logic [DWIDTH-1:0] PC_Plus4,
  output logic              Fetch_Req,
  output logic              Trap_Flag,
  output logic [DWIDTH-1:0] Epc,
  output logic [1:0]        Seq_State
);

  seq_state_t        state, next_state;
  pc_sel_t           sel;
  logic [DWIDTH-1:0] next_pc;
  logic              pc_load;
  logic              trap_take;

  pc_next_mux #(
    .DWIDTH  (DWIDTH),
    .TRAP_VEC(TRAP_VEC)
  ) u_pc_next_mux (
    .pc           (PC),
    .trap_req     (Trap_Req),
    .jump         (Jump),
    .jump_target  (Jump_Target),
    .branch_taken (Branch_Taken),
    .branch_target(Branch_Target),
    .pc_plus4     (PC_Plus4),
    .next_pc      (next_pc),
    .sel          (sel)
  );

  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) state <= ST_BOOT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pc_load    = 1'b0;
    trap_take  = 1'b0;
    case (state)
      ST_BOOT: next_state = ST_RUN;
      ST_RUN: begin
        if (Trap_Req) begin
          trap_take = 1'b1;
        end else if (Stall) begin
          next_state = ST_HOLD;
        end else if (Fetch_Ack) begin
          // A misaligned target surfaces here as SEL_TRAP only when enabled.
          if (sel == SEL_TRAP) trap_take = 1'b1;
          else                 pc_load   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (Trap_Req)    trap_take  = 1'b1;
        else if (!Stall) next_state = ST_RUN;
      end
      ST_TRAP: next_state = ST_RUN;
    endcase
    if (trap_take) next_state = ST_TRAP;
  end

  // On a trap the mux already presents TRAP_VEC, so one load path serves both.
  always_ff @(posedge Clk or negedge N_Rst) begin
    if (!N_Rst) begin
      PC        <= RESET_VEC;
      Epc       <= '0;
      Trap_Flag <= 1'b0;
    end else begin
      Trap_Flag <= trap_take;
      if (pc_load || trap_take) PC  <= next_pc;
      if (trap_take)            Epc <= PC;
    end
  end

  assign Fetch_Req = (state == ST_RUN);
  assign Seq_State = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a behavioural model
module tb_pc_sequencer;

  logic        Clk;
  logic        N_Rst;
  logic        Stall;
  logic        Fetch_Ack;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        Jump;
  logic [31:0] Jump_Target;
  logic        Trap_Req;
  logic [31:0] PC;
  logic [31:0] PC_Plus4;
  logic        Fetch_Req;
  logic        Trap_Flag;
  logic [31:0] Epc;
  logic [1:0]  Seq_State;

  pc_sequencer dut (
    .Clk          (Clk),
    .N_Rst        (N_Rst),
    .Stall        (Stall),
    .Fetch_Ack    (Fetch_Ack),
    .Branch_Taken (Branch_Taken),
    .Branch_Target(Branch_Target),
    .Jump         (Jump),
    .Jump_Target  (Jump_Target),
    .Trap_Req     (Trap_Req),
    .PC           (PC),
    .PC_Plus4     (PC_Plus4),
    .Fetch_Req    (Fetch_Req),
    .Trap_Flag    (Trap_Flag),
    .Epc          (Epc),
    .Seq_State    (Seq_State)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
  localparam bit MIS_TRAP = 1'b1;
`else
  localparam bit MIS_TRAP = 1'b0;
`endif

  // Model: mode 0 boot, 1 run, 2 hold, 3 trap.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_flag;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc",        PC,              m_pc);
    chk("pc_plus4",  PC_Plus4,        m_pc + 32'd4);
    chk("fetch_req", 32'(Fetch_Req),  32'(m_mode == 1));
    chk("trap_flag", 32'(Trap_Flag),  32'(m_flag));
    chk("epc",       Epc,             m_epc);
    chk("state",     32'(Seq_State),  32'(m_mode));
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 32'h0;
    m_epc  = 32'h0;
    m_flag = 1'b0;
  endtask

  task automatic model_trap();
    m_epc  = m_pc;
    m_pc   = 32'h100;
    m_mode = 3;
    m_flag = 1'b1;
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    m_flag = 1'b0;
    if (m_mode == 0 || m_mode == 3) begin
      m_mode = 1;
    end else if (Trap_Req) begin
      model_trap();
    end else if (m_mode == 2) begin
      if (!Stall) m_mode = 1;
    end else if (Stall) begin
      m_mode = 2;
    end else if (Fetch_Ack) begin
      tgt = Jump ? Jump_Target - (Jump_Target % 2) : Branch_Target;
      if (!(Jump || Branch_Taken))            m_pc = m_pc + 32'd4;
      else if (MIS_TRAP && (tgt % 4 != 0))     model_trap();
      else                                     m_pc = tgt - (tgt % 4);
    end
  endtask

  task automatic drive(input bit st, input bit ack, input bit br, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt, input bit tr);
    Stall = st; Fetch_Ack = ack; Branch_Taken = br; Branch_Target = bt;
    Jump = j; Jump_Target = jt; Trap_Req = tr;
  endtask

  task automatic step();
    model_step();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic goto_pc(input logic [31:0] a);
    drive(0, 1, 0, 0, 1, a, 0);
    step();
  endtask

  initial begin
    N_Rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 N_Rst = 1'b0;
    model_reset();
    @(posedge Clk);
    #1;
    check_all();

    // Release with Fetch_Ack high: BOOT, then 0,4,8,12.
    drive(0, 1, 0, 0, 0, 0, 0);
    N_Rst = 1'b1;
    #1;
    check_all();
    for (int i = 0; i < 4; i++) step();

    // Branch from 0x10 to 0x40, then stalled branch holds.
    goto_pc(32'h10);
    drive(0, 1, 1, 32'h40, 0, 0, 0); step();
    goto_pc(32'h10);
    drive(1, 1, 1, 32'h40, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0, 0, 0);      step();
    drive(0, 0, 0, 0, 0, 0, 0);      step();

    // Jump wins over branch; bit 0 of jump target cleared.
    goto_pc(32'h20);
    drive(0, 1, 1, 32'h40, 1, 32'h81, 0); step();

    // Misaligned branch target.
    goto_pc(32'h30);
    drive(0, 1, 1, 32'h42, 0, 0, 0); step();
    drive(0, 1, 0, 0, 0, 0, 0);      step();

    // Trap while stalled, trap request ignored in TRAP.
    goto_pc(32'h50);
    drive(1, 1, 0, 0, 0, 0, 1); step();
    drive(0, 1, 0, 0, 0, 0, 1); step();
    drive(0, 1, 0, 0, 0, 0, 0); step();

    // Fetch_Ack low holds PC in RUN.
    drive(0, 0, 1, 32'h200, 0, 0, 0); step();

    // Wrap at the top of the address space.
    goto_pc(32'hFFFF_FFFC);
    drive(0, 1, 0, 0, 0, 0, 0); step();

    // Reset mid-HOLD.
    drive(1, 1, 0, 0, 0, 0, 0); step();
    N_Rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 N_Rst = 1'b1;
    // Trap_Req in BOOT is ignored.
    drive(0, 1, 0, 0, 0, 0, 1); step();

    // Reset mid-TRAP.
    drive(0, 1, 0, 0, 0, 0, 1); step();
    N_Rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 N_Rst = 1'b1;
    drive(0, 1, 0, 0, 0, 0, 0);
    step(); step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 4) == 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 4) == 0,
            $urandom,
            $urandom_range(0, 6) == 0,
            $urandom,
            $urandom_range(0, 19) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
